// File: rtl/beep_scheduler.sv
// beep_scheduler: latches three burst requests and serves them one at a time by fixed priority on a single buzzer
module beep_scheduler #(
  parameter int TONE_HALF = 12500,
  parameter int ON_CYC = 5_000_000,
  parameter int OFF_CYC = 5_000_000,
  parameter int GAP_CYC = 10_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req,
  input  logic [8:0] req_cnt,
  input  logic       mute,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] done,
  output logic       beep
);
  localparam int MAX_A = ON_CYC > OFF_CYC ? ON_CYC : OFF_CYC;
  localparam int MAX_CYC = MAX_A > GAP_CYC ? MAX_A : GAP_CYC;
  localparam int CW = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
  localparam int TW = TONE_HALF > 1 ? $clog2(TONE_HALF) : 1;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  state_t state, nxt;
  logic [2:0] pending, remain, set, sel, pick;
  logic [2:0] store [3];
  logic [CW-1:0] cnt, lim;
  logic [TW-1:0] ph;
  logic tone, tc, take, ph_end;
  always_comb begin
    lim = state == ON ? CW'(ON_CYC - 1) : state == OFF ? CW'(OFF_CYC - 1) : CW'(GAP_CYC - 1);
    tc = cnt == lim;
    take = state == IDLE && |pending;
    sel = pending[2] ? 3'b100 : pending[1] ? 3'b010 : 3'b001;
    pick = pending[2] ? store[2] : pending[1] ? store[1] : store[0];
    set = req & {|req_cnt[8:6], |req_cnt[5:3], |req_cnt[2:0]};
    ph_end = ph == TW'(TONE_HALF - 1);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = |pending ? ON : IDLE;
      ON: nxt = tc ? (remain == 3'd1 ? GAP : OFF) : ON;
      OFF: nxt = tc ? ON : OFF;
      default: nxt = tc ? IDLE : GAP;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    beep = tone && state == ON && !mute;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      pending <= '0;
      for (int k = 0; k < 3; k++) store[k] <= '0;
    end else begin
      pending <= set | (pending & ~(take ? sel : 3'b000));
      for (int k = 0; k < 3; k++) if (set[k]) store[k] <= req_cnt[3*k +: 3];
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt <= '0;
      remain <= '0;
      grant <= '0;
      done <= '0;
    end else begin
      cnt <= (state == IDLE || tc) ? '0 : cnt + CW'(1);
      remain <= take ? pick : (state == ON && tc) ? remain - 3'd1 : remain;
      grant <= take ? sel : (state == GAP && tc) ? 3'b000 : grant;
      done <= (state == GAP && tc) ? grant : 3'b000;
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ph <= '0;
      tone <= 1'b0;
    end else if (nxt == ON && state != ON) begin
      ph <= '0;
      tone <= 1'b1;
    end else if (state == ON) begin
      ph <= ph_end ? '0 : ph + TW'(1);
      tone <= ph_end ? ~tone : tone;
    end
endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: randomized scoreboard bench for beep_scheduler against a burst-level timing model
module tb_beep_scheduler;
  localparam int TH = 2, ONC = 8, OFFC = 4, GAPC = 6;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [8:0] req_cnt = '0;
  logic mute = 1'b0;
  logic [2:0] grant, done;
  logic busy, beep;
  typedef struct {int idx; int n; int start; int fin;} rec_t;
  rec_t q[$];
  rec_t cur;
  bit active = 0;
  int e = 0, total = 0, passed = 0, free_e = 0;
  logic [2:0] pend_m = '0;
  int store_m [3];
  beep_scheduler #(.TONE_HALF(TH), .ON_CYC(ONC), .OFF_CYC(OFFC), .GAP_CYC(GAPC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req), .req_cnt(req_cnt), .mute(mute),
    .grant(grant), .busy(busy), .done(done), .beep(beep)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, exp);
  endtask
  function automatic int exp_beep(input int o, input int n, input logic m);
    int k = o / (ONC + OFFC);
    int r = o % (ONC + OFFC);
    return (!m && k < n && r < ONC && (r / TH) % 2 == 0) ? 1 : 0;
  endfunction
  task automatic model_step();
    int i, n, d;
    if (!sys_rst_n) begin
      pend_m = '0;
      q.delete();
      free_e = 0;
      return;
    end
    if (e >= free_e && pend_m != 0) begin
      i = pend_m[2] ? 2 : pend_m[1] ? 1 : 0;
      n = store_m[i];
      d = e + n * ONC + (n - 1) * OFFC + GAPC;
      q.push_back('{i, n, e, d});
      free_e = d + 1;
      pend_m[i] = 1'b0;
    end
    for (int j = 0; j < 3; j++)
      if (req[j] && req_cnt[3*j +: 3] != 0) begin
        pend_m[j] = 1'b1;
        store_m[j] = int'(req_cnt[3*j +: 3]);
      end
  endtask
  always @(posedge sys_clk) begin
    e++;
    model_step();
  end
  always @(posedge sys_clk) begin
    #1;
    if (!sys_rst_n) active = 0;
    else begin
      if (!active && grant != 0) begin
        if (q.size() == 0) chk("unexpected_grant", int'(grant), 0);
        else begin
          cur = q.pop_front();
          active = 1;
          chk("grant_start_edge", e, cur.start);
        end
      end
      if (active) begin
        if (e < cur.fin) begin
          chk("grant", int'(grant), 1 << cur.idx);
          chk("busy", int'(busy), 1);
          chk("done_early", int'(done), 0);
          chk("beep", int'(beep), exp_beep(e - cur.start, cur.n, mute));
        end else begin
          chk("done", int'(done), 1 << cur.idx);
          chk("grant_release", int'(grant), 0);
          chk("busy_release", int'(busy), 0);
          chk("beep_after_gap", int'(beep), 0);
          active = 0;
        end
      end else if (grant == 0) begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_beep", int'(beep), 0);
        chk("idle_done", int'(done), 0);
      end
    end
  end
  task automatic pulse(input logic [2:0] r, input logic [8:0] c);
    req = r;
    req_cnt = c;
    @(negedge sys_clk);
    req = '0;
    req_cnt = '0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (q.size() == 0 && !active && pend_m == 0) return;
    end
    chk("idle_timeout", 0, 1);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_grant"}, int'(grant), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_beep"}, int'(beep), 0);
  endtask
  initial begin
    for (int j = 0; j < 3; j++) store_m[j] = 0;
    repeat (3) @(negedge sys_clk);
    chk_zero("in_reset");
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk_zero("after_reset");
    pulse(3'b001, 9'o001);
    wait_idle();
    pulse(3'b001, 9'o003);
    wait_idle();
    pulse(3'b111, 9'o111);
    wait_idle();
    pulse(3'b001, 9'o002);
    repeat (5) @(negedge sys_clk);
    pulse(3'b100, 9'o200);
    repeat (3) @(negedge sys_clk);
    pulse(3'b100, 9'o500);
    wait_idle();
    mute = 1'b1;
    pulse(3'b010, 9'o020);
    wait_idle();
    mute = 1'b0;
    pulse(3'b100, 9'o077);
    repeat (20) @(negedge sys_clk);
    chk_zero("count_zero");
    pulse(3'b001, 9'o003);
    pulse(3'b110, 9'o420);
    repeat (9) @(negedge sys_clk);
    chk("busy_before_reset", int'(busy), 1);
    #2 sys_rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (30) @(negedge sys_clk);
    chk_zero("after_midburst_reset");
    for (int i = 0; i < 400; i++) begin
      mute = $urandom_range(0, 7) == 0;
      req = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      req_cnt = 9'($urandom);
      @(negedge sys_clk);
    end
    req = '0;
    req_cnt = '0;
    mute = 1'b0;
    wait_idle();
    chk("queue_drained", q.size(), 0);
    chk("no_open_burst", int'(active), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
